// File: rtl/vu_pkg.sv
// vu_pkg: constants and types shared by the VU frame parser and the meter
// display logic (sync byte, FSM state encodings, default timeout, checksum).
package vu_pkg;

  // Frame start marker.
  localparam logic [7:0] VU_SYNC = 8'hA5;

  // Default inter-byte timeout: 1 ms at 48 MHz.
  localparam int VU_TIMEOUT_CLKS_DEF = 48000;

  // Parser states, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_GET_L   = 2'd1,
    ST_GET_R   = 2'd2,
    ST_GET_CHK = 2'd3
  } vu_state_e;

  // Frame check byte: plain 8-bit XOR over sync, left and right.
  function automatic logic [7:0] vu_chk(input logic [7:0] left, input logic [7:0] right);
    return VU_SYNC ^ left ^ right;
  endfunction

endpackage

// File: rtl/vu_frame_parser.sv
// vu_frame_parser: extracts left/right VU levels from a UART byte stream.
// Frames are SYNC, LEFT, RIGHT (3 bytes) by default; defining macro
// VU_FRAME_CHECKSUM_EN appends a CHK byte (SYNC^LEFT^RIGHT) and checks it.
// A byte is taken on the rising edge of the UART data-valid level. A partial
// frame is dropped with an error pulse if the next byte does not arrive
// within TIMEOUT_CLKS cycles.
module vu_frame_parser
  import vu_pkg::*;
#(
  parameter int TIMEOUT_CLKS = VU_TIMEOUT_CLKS_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_dv,
  output logic [7:0] o_left,
  output logic [7:0] o_right,
  output logic       o_valid,
  output logic       o_err
);

  localparam int              CNT_W    = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CLKS - 1);

  vu_state_e        r_state;
  vu_state_e        w_state_next;
  logic             r_dv_q;
  logic             w_byte;
  logic [CNT_W-1:0] r_cnt;
  logic             w_expire;
  logic [7:0]       r_left_tmp;
  logic             w_latch_l;
  logic             w_commit;
  logic             w_fail;
  logic [7:0]       w_commit_right;
  logic [7:0]       r_left;
  logic [7:0]       r_right;
  logic             r_valid;
  logic             r_err;

  // A held-high data-valid must not be re-consumed, so only its rising edge
  // counts as a byte.
  assign w_byte   = i_dv & ~r_dv_q;
  // Expiry is only meaningful mid-frame; a coincident byte overrides it below.
  assign w_expire = (r_state != ST_HUNT) && (r_cnt == CNT_LAST);

  // Data-valid edge detector; resets high so a level already up at reset
  // release is not mistaken for a fresh byte.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_dv_q <= 1'b1;
    else       r_dv_q <= i_dv;
  end

  // Inter-byte timeout counter: cleared by every byte, held at 0 in HUNT,
  // saturates at its last value instead of wrapping.
  always_ff @(posedge i_clk) begin
    if (i_rst || (r_state == ST_HUNT) || w_byte) r_cnt <= '0;
    else if (r_cnt != CNT_LAST)                  r_cnt <= r_cnt + CNT_W'(1);
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_HUNT;
    else       r_state <= w_state_next;
  end

`ifdef VU_FRAME_CHECKSUM_EN
  logic [7:0] r_right_tmp;
  logic       w_latch_r;

  // Right level is held until the check byte confirms the frame.
  always_ff @(posedge i_clk) begin
    if (i_rst)          r_right_tmp <= 8'h00;
    else if (w_latch_r) r_right_tmp <= i_data;
  end

  assign w_commit_right = r_right_tmp;
`else
  // Without a check byte the frame commits on the RIGHT byte itself.
  assign w_commit_right = i_data;
`endif

  // Next-state and control decode; a byte always takes priority over expiry.
  always_comb begin
    w_state_next = r_state;
    w_latch_l    = 1'b0;
    w_commit     = 1'b0;
    w_fail       = 1'b0;
`ifdef VU_FRAME_CHECKSUM_EN
    w_latch_r    = 1'b0;
`endif
    if (w_byte) begin
      case (r_state)
        ST_HUNT: begin
          if (i_data == VU_SYNC) w_state_next = ST_GET_L;
        end
        ST_GET_L: begin
          w_latch_l    = 1'b1;
          w_state_next = ST_GET_R;
        end
        ST_GET_R: begin
`ifdef VU_FRAME_CHECKSUM_EN
          w_latch_r    = 1'b1;
          w_state_next = ST_GET_CHK;
`else
          w_commit     = 1'b1;
          w_state_next = ST_HUNT;
`endif
        end
        ST_GET_CHK: begin
`ifdef VU_FRAME_CHECKSUM_EN
          if (i_data == vu_chk(r_left_tmp, r_right_tmp)) w_commit = 1'b1;
          else                                            w_fail   = 1'b1;
`endif
          w_state_next = ST_HUNT;
        end
        default: w_state_next = ST_HUNT;
      endcase
    end else if (w_expire) begin
      w_fail       = 1'b1;
      w_state_next = ST_HUNT;
    end
  end

  // Left level staging register, filled in GET_L.
  always_ff @(posedge i_clk) begin
    if (i_rst)          r_left_tmp <= 8'h00;
    else if (w_latch_l) r_left_tmp <= i_data;
  end

  // Output registers: levels move only on a committed frame; pulses last one
  // cycle and are mutually exclusive by construction of the decode.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_left  <= 8'h00;
      r_right <= 8'h00;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= w_commit;
      r_err   <= w_fail;
      if (w_commit) begin
        r_left  <= r_left_tmp;
        r_right <= w_commit_right;
      end
    end
  end

  assign o_left  = r_left;
  assign o_right = r_right;
  assign o_valid = r_valid;
  assign o_err   = r_err;

endmodule

// File: tb/tb_vu_frame_parser.sv
// Directed testbench for vu_frame_parser. Runs against the default 3-byte
// build, or the 4-byte checked build when VU_FRAME_CHECKSUM_EN is defined.
module tb_vu_frame_parser;

  localparam int TO = 6000;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [7:0] i_data = 8'h00;
  logic       i_dv = 1'b0;
  logic [7:0] o_left;
  logic [7:0] o_right;
  logic       o_valid;
  logic       o_err;

  int n_cmp = 0;
  int n_fail = 0;
  int valid_cnt = 0;
  int err_cnt = 0;

  vu_frame_parser #(.TIMEOUT_CLKS(TO)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_data (i_data),
    .i_dv   (i_dv),
    .o_left (o_left),
    .o_right(o_right),
    .o_valid(o_valid),
    .o_err  (o_err)
  );

  always #5 i_clk = ~i_clk;

  // Pulse counters, sampled on the falling edge.
  always @(negedge i_clk) begin
    if (o_valid) valid_cnt <= valid_cnt + 1;
    if (o_err)   err_cnt   <= err_cnt + 1;
    if (o_valid && o_err) begin
      n_cmp  <= n_cmp + 1;
      n_fail <= n_fail + 1;
      $display("FAIL valid_err_exclusive: o_valid=1 o_err=1 together, required not both");
    end
  end

  task automatic tick();
    @(negedge i_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_data = b;
    i_dv   = 1'b1;
    repeat (3) tick();
    i_dv   = 1'b0;
    repeat (2) tick();
  endtask

  task automatic send_frame(input logic [7:0] l, input logic [7:0] r);
    send_byte(8'hA5);
    send_byte(l);
    send_byte(r);
`ifdef VU_FRAME_CHECKSUM_EN
    send_byte(8'hA5 ^ l ^ r);
`endif
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_dv  = 1'b0;
    repeat (3) tick();
    n_cmp++; if (o_left !== 8'h00) begin n_fail++; $display("FAIL reset_left: got %h want 00", o_left); end
    n_cmp++; if (o_right !== 8'h00) begin n_fail++; $display("FAIL reset_right: got %h want 00", o_right); end
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    n_cmp++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", o_err); end
    i_rst = 1'b0;
    repeat (2) tick();
  endtask

  // 0x33 ignored in HUNT, then frame 07/09; final byte checked for latency.
  task automatic test_frame();
    logic [7:0] fin;
    int e0;
    e0 = err_cnt;
    send_byte(8'h33);
    send_byte(8'hA5);
    send_byte(8'h07);
`ifdef VU_FRAME_CHECKSUM_EN
    send_byte(8'h09);
    fin = 8'hAB;
`else
    fin = 8'h09;
`endif
    n_cmp++; if (o_left !== 8'h00) begin n_fail++; $display("FAIL frame_left_early: got %h want 00", o_left); end
    i_data = fin;
    i_dv   = 1'b1;
    tick();
    n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL frame_valid_latency: got %b want 1", o_valid); end
    n_cmp++; if (o_left !== 8'h07) begin n_fail++; $display("FAIL frame_left: got %h want 07", o_left); end
    n_cmp++; if (o_right !== 8'h09) begin n_fail++; $display("FAIL frame_right: got %h want 09", o_right); end
    tick();
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL frame_valid_one_cycle: got %b want 0", o_valid); end
    i_dv = 1'b0;
    repeat (2) tick();
    n_cmp++; if (err_cnt !== e0) begin n_fail++; $display("FAIL frame_no_err: got %0d want %0d", err_cnt, e0); end
    $display("frame 33,A5,07,09: left=%h right=%h", o_left, o_right);
  endtask

  // Sync byte with data-valid held high for 5000 cycles is consumed once.
  task automatic test_hold();
    int v0, e0;
    v0 = valid_cnt;
    e0 = err_cnt;
    i_data = 8'hA5;
    i_dv   = 1'b1;
    repeat (5000) tick();
    i_dv = 1'b0;
    repeat (2) tick();
    n_cmp++; if (valid_cnt !== v0 || err_cnt !== e0) begin n_fail++; $display("FAIL hold_no_pulse: valid %0d err %0d want %0d %0d", valid_cnt, err_cnt, v0, e0); end
    send_byte(8'h5A);
    send_byte(8'h3C);
`ifdef VU_FRAME_CHECKSUM_EN
    send_byte(8'hC3);
`endif
    n_cmp++; if (valid_cnt !== v0 + 1) begin n_fail++; $display("FAIL hold_valid_cnt: got %0d want %0d", valid_cnt, v0 + 1); end
    n_cmp++; if (o_left !== 8'h5A) begin n_fail++; $display("FAIL hold_left: got %h want 5A", o_left); end
    n_cmp++; if (o_right !== 8'h3C) begin n_fail++; $display("FAIL hold_right: got %h want 3C", o_right); end
    $display("hold A5 for 5000 cycles then 5A,3C: left=%h right=%h", o_left, o_right);
  endtask

  // A5,10 then silence: o_err exactly TO cycles after the last byte edge.
  task automatic test_timeout();
    int v0, e0;
    v0 = valid_cnt;
    e0 = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h10);
    repeat (TO - 5) tick();
    n_cmp++; if (o_err !== 1'b0 || err_cnt !== e0) begin n_fail++; $display("FAIL timeout_early: o_err=%b cnt=%0d want 0 %0d", o_err, err_cnt, e0); end
    tick();
    n_cmp++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b want 1", o_err); end
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_valid: got %b want 0", o_valid); end
    tick();
    n_cmp++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL timeout_err_one_cycle: got %b want 0", o_err); end
    n_cmp++; if (o_left !== 8'h5A) begin n_fail++; $display("FAIL timeout_left_kept: got %h want 5A", o_left); end
    send_frame(8'hA5, 8'hA5);
    n_cmp++; if (o_left !== 8'hA5 || o_right !== 8'hA5) begin n_fail++; $display("FAIL timeout_resync: got %h %h want A5 A5", o_left, o_right); end
    n_cmp++; if (valid_cnt !== v0 + 1 || err_cnt !== e0 + 1) begin n_fail++; $display("FAIL timeout_counts: valid %0d err %0d want %0d %0d", valid_cnt, err_cnt, v0 + 1, e0 + 1); end
    $display("timeout after A5,10 then A5 frame: left=%h right=%h", o_left, o_right);
  endtask

  // Final byte arrives on the very cycle the timeout would expire.
  task automatic test_priority();
    logic [7:0] fin;
    int e0;
    e0 = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h10);
`ifdef VU_FRAME_CHECKSUM_EN
    send_byte(8'h20);
    fin = 8'h95;
`else
    fin = 8'h20;
`endif
    repeat (TO - 5) tick();
    i_data = fin;
    i_dv   = 1'b1;
    tick();
    n_cmp++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL prio_err: got %b want 0", o_err); end
    n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL prio_valid: got %b want 1", o_valid); end
    n_cmp++; if (o_left !== 8'h10 || o_right !== 8'h20) begin n_fail++; $display("FAIL prio_levels: got %h %h want 10 20", o_left, o_right); end
    tick();
    i_dv = 1'b0;
    repeat (2) tick();
    n_cmp++; if (err_cnt !== e0) begin n_fail++; $display("FAIL prio_err_cnt: got %0d want %0d", err_cnt, e0); end
    $display("byte on expiry cycle: left=%h right=%h", o_left, o_right);
  endtask

  // Reset mid-frame, then reset released with data-valid already high.
  task automatic test_reset_midframe();
    int v0, e0;
    v0 = valid_cnt;
    e0 = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h20);
    i_rst = 1'b1;
    repeat (2) tick();
    n_cmp++; if (o_left !== 8'h00 || o_right !== 8'h00) begin n_fail++; $display("FAIL rstmid_levels: got %h %h want 00 00", o_left, o_right); end
    i_data = 8'hA5;
    i_dv   = 1'b1;
    tick();
    i_rst = 1'b0;
    repeat (4) tick();
    i_dv = 1'b0;
    repeat (2) tick();
    n_cmp++; if (valid_cnt !== v0 || err_cnt !== e0) begin n_fail++; $display("FAIL rstmid_no_pulse: valid %0d err %0d want %0d %0d", valid_cnt, err_cnt, v0, e0); end
    n_cmp++; if (o_left !== 8'h00 || o_right !== 8'h00) begin n_fail++; $display("FAIL rstmid_after_release: got %h %h want 00 00", o_left, o_right); end
    send_frame(8'h07, 8'h09);
    n_cmp++; if (o_left !== 8'h07 || o_right !== 8'h09) begin n_fail++; $display("FAIL rstmid_next_frame: got %h %h want 07 09", o_left, o_right); end
    n_cmp++; if (valid_cnt !== v0 + 1 || err_cnt !== e0) begin n_fail++; $display("FAIL rstmid_counts: valid %0d err %0d want %0d %0d", valid_cnt, err_cnt, v0 + 1, e0); end
    $display("reset mid-frame, dv high at release, then frame: left=%h right=%h", o_left, o_right);
  endtask

`ifdef VU_FRAME_CHECKSUM_EN
  // Bad check byte keeps prior levels; good frame afterwards is accepted.
  task automatic test_checksum();
    int v0, e0;
    send_frame(8'h01, 8'h02);
    v0 = valid_cnt;
    e0 = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h40);
    send_byte(8'hC0);
    send_byte(8'h00);
    n_cmp++; if (err_cnt !== e0 + 1 || valid_cnt !== v0) begin n_fail++; $display("FAIL chk_bad_counts: valid %0d err %0d want %0d %0d", valid_cnt, err_cnt, v0, e0 + 1); end
    n_cmp++; if (o_left !== 8'h01 || o_right !== 8'h02) begin n_fail++; $display("FAIL chk_bad_kept: got %h %h want 01 02", o_left, o_right); end
    send_byte(8'hA5);
    send_byte(8'h40);
    send_byte(8'hC0);
    send_byte(8'h25);
    n_cmp++; if (valid_cnt !== v0 + 1 || err_cnt !== e0 + 1) begin n_fail++; $display("FAIL chk_good_counts: valid %0d err %0d want %0d %0d", valid_cnt, err_cnt, v0 + 1, e0 + 1); end
    n_cmp++; if (o_left !== 8'h40 || o_right !== 8'hC0) begin n_fail++; $display("FAIL chk_good_levels: got %h %h want 40 C0", o_left, o_right); end
    $display("checksum bad then good A5,40,C0,25: left=%h right=%h", o_left, o_right);
  endtask
`endif

  initial begin
    test_reset();
    test_frame();
    test_hold();
    test_timeout();
    test_priority();
    test_reset_midframe();
`ifdef VU_FRAME_CHECKSUM_EN
    test_checksum();
`endif
    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
